clint_timer: RTL
================

// Module: clint_timer
// PURPOSE
//  Core-local interruptor for the RV64 core. Holds mtime/mtimecmp/msip behind a valid/ready MMIO port.
//  Drives the CSR unit's timer-pending input (mtime_intr_i -> mip.MTIP) and a software-interrupt line.
//  Sits between the data-memory bus decoder and the CSR block; single hart, M-mode only.
// PARAMETERS
//  ADDR_W   32          request address width
//  BASE     32'h0200_0000 CLINT base; msip @+0x0000, mtimecmp @+0x4000, mtime @+0xBFF8
//  TICK_DIV 1           clk cycles per mtime increment (>=1; 1 = every cycle)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  req_valid    in   1       bus request valid
//  req_ready    out  1       block can accept request
//  req_we       in   1       1 = write, 0 = read
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   64      write data
//  req_wstrb    in   8       byte enables for write
//  resp_valid   out  1       response valid
//  resp_ready   in   1       consumer accepts response
//  resp_rdata   out  64      read data (0 for writes/errors)
//  resp_err     out  1       access fault (unmapped or misaligned)
//  mtime_intr_o out  1       timer interrupt pending (mtime >= mtimecmp)
//  msip_o       out  1       software interrupt pending (msip[0])
// BEHAVIOUR
//  Reset (rst=0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0,
//   state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mtime_intr_o=0, msip_o=0.
//  FSM: IDLE -> RESP on req_valid&req_ready; RESP -> IDLE on resp_ready when no new accept;
//   RESP -> RESP on resp_ready with new accept (back-to-back).
//  req_ready = (state==IDLE) | resp_ready. One outstanding request; no internal queue.
//  Latency: response registered, resp_valid asserted the cycle after accept; held with
//   rdata/err stable until resp_ready sampled high.
//  Decode on accepted req_addr: offset = req_addr-BASE; 0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime.
//   addr[2:0]!=0 or unmapped offset -> resp_err=1, rdata=0, no state change.
//  Reads: rdata = register value at accept edge (pre-increment mtime). msip reads {63'b0,msip}.
//  Writes: byte-merged per req_wstrb; msip keeps bit0 only. wstrb=0 -> no change, resp_err=0.
//  Prescaler: counts 0..TICK_DIV-1; mtime+=1 (mod 2^64, FFFF..FF -> 0) when prescaler==TICK_DIV-1.
//  mtime write in same cycle as tick: written value wins, tick dropped, prescaler cleared to 0.
//  mtime_intr_o: registered unsigned compare of current mtime>=mtimecmp; follows change 1 cycle
//   later; level, clears only when mtimecmp raised or mtime rewritten below it.
//  msip_o: registered copy of msip, visible cycle after write.
//  Reset mid-transaction: pending response dropped, resp_valid=0 immediately.
// TESTING
//  T1 reset: rst low, check mtime=0, mtimecmp=all-ones, mtime_intr_o=0, resp_valid=0.
//  T2 tick: TICK_DIV=4, run 40 clk, read mtime@0x0200BFF8 -> 10 (+/-1 for accept cycle), err=0.
//  T3 compare: write mtimecmp=0x20 (wstrb=FF); intr_o rises 1 cycle after mtime reaches 0x20;
//     write mtimecmp=0x100 -> intr_o falls next cycle.
//  T4 wrap/priority: write mtime=64'hFFFF_FFFF_FFFF_FFFF, next tick -> mtime=0;
//     mtime write coincident with tick -> written value read back, prescaler restarts.
//  T5 bus: strobed write wstrb=8'h0F data 0x1111_2222_3333_4444 to mtimecmp -> low word only;
//     addr 0x0200_4004 -> resp_err=1; addr 0x0200_8000 -> err=1, rdata=0; resp_ready held low
//     5 cycles -> resp stable, req_ready=0.
//  T6 msip: write 0x3 to msip -> read 0x1, msip_o=1 next cycle; write 0 -> msip_o=0.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor holding mtime/mtimecmp/msip behind
// a single-outstanding valid/ready MMIO port; drives MTIP and MSIP.
module clint_timer #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    BASE     = ADDR_W'(32'h0200_0000),
    parameter int unsigned          TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mtime_intr_o,
    output logic              msip_o
);

    localparam int unsigned PW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [ADDR_W-1:0] OFF_MSIP = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_CMP  = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_TIME = ADDR_W'(16'hBFF8);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          intr_q, intr_d;
    logic          msip_o_q, msip_o_d;

    logic              accept;
    logic              tick;
    logic              hit_msip;
    logic              hit_cmp;
    logic              hit_time;
    logic              bad;
    logic              wr;
    logic [ADDR_W-1:0] offset;
    logic [63:0]       wmask;
    logic [63:0]       rd_val;
    logic [63:0]       msip_new;

    assign req_ready = (state_q == IDLE) | resp_ready;
    assign accept    = req_valid & req_ready;

    assign offset   = req_addr - BASE;
    assign hit_msip = (offset == OFF_MSIP);
    assign hit_cmp  = (offset == OFF_CMP);
    assign hit_time = (offset == OFF_TIME);
    assign bad      = (req_addr[2:0] != 3'b000)
                    | ~(hit_msip | hit_cmp | hit_time);
    // An empty strobe is a legal no-op, so it must not disturb the prescaler
    assign wr       = accept & req_we & ~bad & (|req_wstrb);

    assign tick = (presc_q == PMAX);

    always_comb begin
        wmask = '0;
        for (int i = 0; i < 8; i++) begin
            wmask[i*8 +: 8] = {8{req_wstrb[i]}};
        end
    end

    always_comb begin
        rd_val = mtime_q;
        unique case (1'b1)
            hit_msip: rd_val = {63'b0, msip_q};
            hit_cmp:  rd_val = mtimecmp_q;
            default:  rd_val = mtime_q;
        endcase
    end

    assign msip_new = ({63'b0, msip_q} & ~wmask)
                    | (req_wdata & wmask);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: if (resp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            err_d   = bad;
            rdata_d = (!req_we && !bad) ? rd_val : 64'd0;
        end
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = mtime_q + {63'b0, tick};
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        // A software write to mtime overrides the tick and realigns it
        if (wr && hit_time) begin
            mtime_d = (mtime_q & ~wmask) | (req_wdata & wmask);
            presc_d = '0;
        end
        if (wr && hit_cmp) begin
            mtimecmp_d = (mtimecmp_q & ~wmask)
                       | (req_wdata & wmask);
        end
        if (wr && hit_msip) begin
            msip_d = msip_new[0];
        end
    end

    assign intr_d   = (mtime_q >= mtimecmp_q);
    assign msip_o_d = msip_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            presc_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            intr_q     <= 1'b0;
            msip_o_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            intr_q     <= intr_d;
            msip_o_q   <= msip_o_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign mtime_intr_o = intr_q;
    assign msip_o       = msip_o_q;

endmodule
